ram_dump32: RTL and testbench

Read-back counterpart of the boot ROM-to-RAM loader. After load completes, it walks the 32-bit byte-addressed RAM word by word and issues one read per word. It presents each word on a valid/ready stream for the simulation monitor or the UART dump path. It sits beside the loader on the same RAM port mux and shares its clock and reset.

---
 rtl/ba22_mem_pkg.sv | 10 +
 rtl/ram_dump_outreg.sv | 30 +++
 rtl/ram_dump32.sv | 105 ++++++++++
 tb/tb_ram_dump32.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ba22_mem_pkg.sv
// ba22_mem_pkg: shared RAM geometry, address shift and dump FSM states
// used by the boot loader and the RAM dump engine.
package ba22_mem_pkg;
    localparam int RAM_AW      = 32;
    localparam int DATA_W      = 32;
    localparam int DEF_WORD_AW = 12;
    localparam int ADDR_SHIFT  = 2;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE} dump_state_t;
endpackage

// File: rtl/ram_dump_outreg.sv
// ram_dump_outreg: output holding register for the dump stream; data/addr
// stay frozen while valid is high until the sink accepts.
module ram_dump_outreg #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [AW-1:0] load_addr,
    input  logic          ready,
    output logic [DW-1:0] data,
    output logic [AW-1:0] addr,
    output logic          valid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            addr  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            addr  <= load_addr;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/ram_dump32.sv
// ram_dump32: walks the RAM word by word after load and streams each word out.
// Define RAM_DUMP_CHECKSUM_EN to add the dump_csum running-sum output.
module ram_dump32
    import ba22_mem_pkg::*;
#(
    parameter int WORD_AW = DEF_WORD_AW,
    parameter int RD_LAT  = 1
) (
    input  logic               clk_load,
    input  logic               KEY,
    input  logic               start_dump,
    output logic [RAM_AW-1:0]  addr_ram,
    output logic               rd_en,
    input  logic [DATA_W-1:0]  data_out_ram,
    output logic [DATA_W-1:0]  dump_data,
    output logic [WORD_AW-1:0] dump_addr,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic               busy,
    output logic               dump_done
`ifdef RAM_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]  dump_csum
`endif
);
    dump_state_t        state;
    logic [WORD_AW-1:0] word_idx;
    logic [1:0]         wait_cnt;
    logic               capture, accept, start_ok;

    assign capture  = state == WAIT && wait_cnt == 2'd1;
    assign accept   = state == HOLD && dump_valid && dump_ready;
    assign start_ok = (state == IDLE || state == DONE) && start_dump;

    function automatic logic [RAM_AW-1:0] byte_addr(input logic [WORD_AW-1:0] idx);
        return RAM_AW'(idx) << ADDR_SHIFT;
    endfunction

    // Outputs are registered, so rd_en/addr_ram are set on the edge entering ISSUE.
    always_ff @(posedge clk_load or negedge KEY) begin
        if (!KEY) begin
            state     <= IDLE;
            word_idx  <= '0;
            addr_ram  <= '0;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start_dump) begin
                    state     <= ISSUE;
                    word_idx  <= '0;
                    addr_ram  <= '0;
                    rd_en     <= 1'b1;
                    busy      <= 1'b1;
                    dump_done <= 1'b0;
                end
                ISSUE: begin
                    rd_en    <= 1'b0;
                    wait_cnt <= 2'(RD_LAT);
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 2'd1;
                    if (capture) state <= HOLD;
                end
                HOLD: if (accept) begin
                    if (&word_idx) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        dump_done <= 1'b1;
                        addr_ram  <= '0;
                    end else begin
                        word_idx <= word_idx + WORD_AW'(1);
                        addr_ram <= byte_addr(word_idx + WORD_AW'(1));
                        rd_en    <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ram_dump_outreg #(.AW(WORD_AW), .DW(DATA_W)) u_outreg (
        .clk       (clk_load),
        .rst_n     (KEY),
        .load      (capture),
        .load_data (data_out_ram),
        .load_addr (word_idx),
        .ready     (dump_ready),
        .data      (dump_data),
        .addr      (dump_addr),
        .valid     (dump_valid)
    );

`ifdef RAM_DUMP_CHECKSUM_EN
    always_ff @(posedge clk_load or negedge KEY) begin
        if (!KEY)          dump_csum <= '0;
        else if (start_ok) dump_csum <= '0;
        else if (accept)   dump_csum <= dump_csum + dump_data;
    end
`endif
endmodule

// File: tb/tb_ram_dump32.sv
// tb_ram_dump32: scoreboard bench for ram_dump32 with an 8-word RAM model,
// one instance at read latency 1 and one at read latency 2.
module tb_ram_dump32;
    logic        clk = 0, key = 0, start = 0, start2 = 0, ready = 1;
    logic [31:0] addr_ram, addr_ram2, q1, p1, p2, dump_data, dump_data2;
    logic [2:0]  dump_addr, dump_addr2;
    logic        rd_en, rd_en2, dump_valid, dump_valid2, busy, busy2, dump_done, dump_done2;
    logic [31:0] mem [8];
    logic [34:0] exp_q [$];
    int          checks = 0, errors = 0;
`ifdef RAM_DUMP_CHECKSUM_EN
    logic [31:0] dump_csum, dump_csum2;
`endif

    always #5 clk = ~clk;

    ram_dump32 #(.WORD_AW(3), .RD_LAT(1)) dut (
        .clk_load(clk), .KEY(key), .start_dump(start), .addr_ram(addr_ram), .rd_en(rd_en),
        .data_out_ram(q1), .dump_data(dump_data), .dump_addr(dump_addr), .dump_valid(dump_valid),
        .dump_ready(ready), .busy(busy), .dump_done(dump_done)
`ifdef RAM_DUMP_CHECKSUM_EN
        , .dump_csum(dump_csum)
`endif
    );

    ram_dump32 #(.WORD_AW(3), .RD_LAT(2)) dut2 (
        .clk_load(clk), .KEY(key), .start_dump(start2), .addr_ram(addr_ram2), .rd_en(rd_en2),
        .data_out_ram(p2), .dump_data(dump_data2), .dump_addr(dump_addr2), .dump_valid(dump_valid2),
        .dump_ready(ready), .busy(busy2), .dump_done(dump_done2)
`ifdef RAM_DUMP_CHECKSUM_EN
        , .dump_csum(dump_csum2)
`endif
    );

    always @(posedge clk) if (rd_en) q1 <= mem[addr_ram[4:2]];
    always @(posedge clk) begin
        if (rd_en2) p1 <= mem[addr_ram2[4:2]];
        p2 <= p1;
    end

    task automatic expect_all();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), mem[i]});
    endtask

    task automatic kick();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic test_reset();
        key = 0;
        #12;
        checks++;
        if ({addr_ram, rd_en, dump_data, dump_addr, dump_valid, busy, dump_done} !== '0) begin
            errors++;
            $display("FAIL reset_state: addr=%h rd_en=%b data=%h daddr=%0d valid=%b busy=%b done=%b (all 0 expected)",
                     addr_ram, rd_en, dump_data, dump_addr, dump_valid, busy, dump_done);
        end
        @(negedge clk);
        key = 1;
        ready = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (rd_en !== 0 || dump_valid !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL idle_ready_no_effect: rd_en=%b valid=%b busy=%b expected 0 0 0", rd_en, dump_valid, busy);
        end
    endtask

    task automatic test_basic();
        int issues = 0, hs = 0, c;
        logic [34:0] e;
        expect_all();
        kick();
        for (c = 0; c < 200 && !dump_done; c++) begin
            if (rd_en) begin
                checks++;
                if (addr_ram !== 32'(issues * 4)) begin
                    errors++;
                    $display("FAIL basic_addr: addr_ram=%h expected %h", addr_ram, issues * 4);
                end
                issues++;
            end
            if (dump_valid && ready) begin
                e = exp_q.size() ? exp_q.pop_front() : 'x;
                checks++;
                if ({dump_addr, dump_data} !== e) begin
                    errors++;
                    $display("FAIL basic_word: addr=%0d data=%h expected addr=%0d data=%h", dump_addr, dump_data, e[34:32], e[31:0]);
                end
                hs++;
            end
            @(negedge clk);
        end
        checks++;
        if (c != 24 || issues != 8 || hs != 8 || busy !== 0 || addr_ram !== 0 || dump_done !== 1) begin
            errors++;
            $display("FAIL basic_done: cycles=%0d issues=%0d hs=%0d busy=%b addr=%h done=%b expected 24 8 8 0 0 1",
                     c, issues, hs, busy, addr_ram, dump_done);
        end
    endtask

    task automatic test_backpressure();
        int issues = 0, hs = 0, c;
        bit stalled = 0;
        logic [34:0] e;
        expect_all();
        kick();
        for (c = 0; c < 200 && !dump_done; c++) begin
            if (rd_en) begin
                checks++;
                if (addr_ram !== 32'(issues * 4)) begin
                    errors++;
                    $display("FAIL bp_addr: addr_ram=%h expected %h", addr_ram, issues * 4);
                end
                issues++;
            end
            if (dump_valid && dump_addr == 3'd2 && !stalled) begin
                stalled = 1;
                ready = 0;
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (dump_valid !== 1 || dump_addr !== 3'd2 || dump_data !== mem[2] || rd_en !== 0) begin
                        errors++;
                        $display("FAIL bp_hold: valid=%b addr=%0d data=%h rd_en=%b expected 1 2 %h 0",
                                 dump_valid, dump_addr, dump_data, rd_en, mem[2]);
                    end
                end
                ready = 1;
            end
            if (dump_valid && ready) begin
                e = exp_q.size() ? exp_q.pop_front() : 'x;
                checks++;
                if ({dump_addr, dump_data} !== e) begin
                    errors++;
                    $display("FAIL bp_word: addr=%0d data=%h expected addr=%0d data=%h", dump_addr, dump_data, e[34:32], e[31:0]);
                end
                hs++;
            end
            @(negedge clk);
        end
        checks++;
        if (!stalled || issues != 8 || hs != 8 || dump_done !== 1) begin
            errors++;
            $display("FAIL bp_done: stalled=%b issues=%0d hs=%0d done=%b expected 1 8 8 1", stalled, issues, hs, dump_done);
        end
    endtask

    task automatic test_start_busy();
        int issues = 0, hs = 0, c;
        bit poked = 0;
        logic [34:0] e;
        expect_all();
        kick();
        for (c = 0; c < 200 && !dump_done; c++) begin
            if (rd_en) begin
                checks++;
                if (addr_ram !== 32'(issues * 4)) begin
                    errors++;
                    $display("FAIL busy_addr: addr_ram=%h expected %h", addr_ram, issues * 4);
                end
                issues++;
            end
            if (dump_valid && dump_addr == 3'd3 && !poked) begin
                poked = 1;
                start = 1;
            end
            if (dump_valid && ready) begin
                e = exp_q.size() ? exp_q.pop_front() : 'x;
                checks++;
                if ({dump_addr, dump_data} !== e) begin
                    errors++;
                    $display("FAIL busy_word: addr=%0d data=%h expected addr=%0d data=%h", dump_addr, dump_data, e[34:32], e[31:0]);
                end
                hs++;
            end
            @(negedge clk);
            start = 0;
        end
        checks++;
        if (!poked || c != 24 || issues != 8 || hs != 8) begin
            errors++;
            $display("FAIL busy_done: poked=%b cycles=%0d issues=%0d hs=%0d expected 1 24 8 8", poked, c, issues, hs);
        end
    endtask

    task automatic test_reset_mid();
        int c, hs = 0;
        logic [34:0] e;
        expect_all();
        kick();
        for (c = 0; c < 50 && !(rd_en && addr_ram == 32'h10); c++) @(negedge clk);
        @(negedge clk);
        key = 0;
        #1;
        checks++;
        if (c >= 50 || {addr_ram, rd_en, dump_data, dump_addr, dump_valid, busy, dump_done} !== '0) begin
            errors++;
            $display("FAIL mid_reset: found_cycle=%0d addr=%h rd_en=%b data=%h daddr=%0d valid=%b busy=%b done=%b expected all 0",
                     c, addr_ram, rd_en, dump_data, dump_addr, dump_valid, busy, dump_done);
        end
        @(negedge clk);
        key = 1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dump_valid !== 0 || rd_en !== 0 || busy !== 0) begin
                errors++;
                $display("FAIL mid_no_partial: valid=%b rd_en=%b busy=%b expected 0 0 0", dump_valid, rd_en, busy);
            end
        end
        expect_all();
        kick();
        checks++;
        if (rd_en !== 1 || addr_ram !== 0) begin
            errors++;
            $display("FAIL mid_restart: rd_en=%b addr=%h expected 1 0", rd_en, addr_ram);
        end
        for (c = 0; c < 200 && !dump_done; c++) begin
            if (dump_valid && ready) begin
                e = exp_q.size() ? exp_q.pop_front() : 'x;
                checks++;
                if ({dump_addr, dump_data} !== e) begin
                    errors++;
                    $display("FAIL mid_word: addr=%0d data=%h expected addr=%0d data=%h", dump_addr, dump_data, e[34:32], e[31:0]);
                end
                hs++;
            end
            @(negedge clk);
        end
        checks++;
        if (hs != 8 || dump_done !== 1) begin
            errors++;
            $display("FAIL mid_done: hs=%0d done=%b expected 8 1", hs, dump_done);
        end
    endtask

    task automatic test_latency2();
        int issues = 0, hs = 0, last_rd = 0, c;
        bit prev_v = 0;
        logic [34:0] e;
        expect_all();
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        for (c = 0; c < 200 && !dump_done2; c++) begin
            if (rd_en2) begin
                last_rd = c;
                checks++;
                if (addr_ram2 !== 32'(issues * 4)) begin
                    errors++;
                    $display("FAIL lat2_addr: addr_ram=%h expected %h", addr_ram2, issues * 4);
                end
                issues++;
            end
            if (dump_valid2 && !prev_v) begin
                checks++;
                if (c - last_rd != 3) begin
                    errors++;
                    $display("FAIL lat2_latency: valid after %0d cycles expected 3", c - last_rd);
                end
            end
            prev_v = dump_valid2;
            if (dump_valid2 && ready) begin
                e = exp_q.size() ? exp_q.pop_front() : 'x;
                checks++;
                if ({dump_addr2, dump_data2} !== e) begin
                    errors++;
                    $display("FAIL lat2_word: addr=%0d data=%h expected addr=%0d data=%h", dump_addr2, dump_data2, e[34:32], e[31:0]);
                end
                hs++;
            end
            @(negedge clk);
        end
        checks++;
        if (c != 32 || issues != 8 || hs != 8) begin
            errors++;
            $display("FAIL lat2_done: cycles=%0d issues=%0d hs=%0d expected 32 8 8", c, issues, hs);
        end
    endtask

`ifdef RAM_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        int c;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = r == 0 ? 32'(i + 1) : 32'hFFFF_FFFF;
            kick();
            checks++;
            if (dump_csum !== 0) begin
                errors++;
                $display("FAIL csum_clear: csum=%h expected 0", dump_csum);
            end
            for (c = 0; c < 200 && !dump_done; c++) @(negedge clk);
            checks++;
            if (dump_csum !== (r == 0 ? 32'd36 : 32'hFFFF_FFF8)) begin
                errors++;
                $display("FAIL csum_final%0d: csum=%h expected %h", r, dump_csum, r == 0 ? 32'd36 : 32'hFFFF_FFF8);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'hA500_0000 + 32'(i);
        test_reset();
        test_basic();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_latency2();
`ifdef RAM_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
